// File: rtl/core_fetch_queue.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// queue tagged with PC, and redirect handling that discards stale responses.
module core_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_Clk,
  input  logic            i_Rstn,
  input  logic            i_StallEn,
  input  logic            i_FlushEn,
  input  logic            i_JumpEn,
  input  logic [XLEN-1:0] i_JumpAddr,
  input  logic            i_BranchEn,
  input  logic [XLEN-1:0] i_BranchAddr,
  output logic            o_ReadEn,
  output logic [XLEN-1:0] o_ReadAddr,
  input  logic            i_ReadGnt,
  input  logic            i_ReadValid,
  input  logic [31:0]     i_ReadData,
  output logic            o_InstrValid,
  output logic [31:0]     o_Instr,
  output logic [XLEN-1:0] o_PC,
  output logic            o_Event
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FULL_CNT = CW'(DEPTH);

  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];

  ptr_t            wr_ptr, rd_ptr;
  cnt_t            count, outstanding, discard;
  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic            event_q;

  logic            redirect, redirect_err;
  logic [XLEN-1:0] raw_target, target;
  logic [CW:0]     in_flight;
  logic            read_en, issue, resp_ret;
  logic            accept, drop_full, drop_discard, pop, queue_full, queue_empty;
  cnt_t            outstanding_n;

  // Flush beats jump beats branch; the target is always word aligned.
  assign redirect     = i_FlushEn | i_JumpEn | i_BranchEn;
  assign raw_target   = i_FlushEn ? RESET_PC : (i_JumpEn ? i_JumpAddr : i_BranchAddr);
  assign target       = {raw_target[XLEN-1:2], 2'b00};
  assign redirect_err = (!i_FlushEn && i_JumpEn && i_BranchEn) || (raw_target[1:0] != 2'b00);

  // Credits count every request still owed a response, discarded ones included.
  assign in_flight   = {1'b0, outstanding} + {1'b0, count};
  assign read_en     = i_Rstn && !redirect && (in_flight < (CW+1)'(DEPTH));
  assign issue       = read_en && i_ReadGnt;
  assign resp_ret    = i_ReadValid && (outstanding != '0);

  assign queue_full   = (count == FULL_CNT);
  assign queue_empty  = (count == '0);
  assign drop_discard = i_ReadValid && (discard != '0);
  assign accept       = i_ReadValid && (discard == '0) && !redirect && !queue_full;
  assign drop_full    = i_ReadValid && (discard == '0) && !redirect && queue_full;
  assign pop          = !queue_empty && !i_StallEn;

  // NOTE: give every always_comb target a default first so no path leaves it unassigned (latch).
  always_comb begin
    outstanding_n = outstanding;
    if (issue)    outstanding_n = outstanding_n + cnt_t'(1);
    if (resp_ret) outstanding_n = outstanding_n - cnt_t'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      event_q     <= 1'b0;
    end else begin
      outstanding <= outstanding_n;
      event_q     <= (redirect && redirect_err) || drop_full;
      if (redirect) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        discard  <= outstanding_n;
        fetch_pc <= target;
        resp_pc  <= target;
      end else begin
        if (issue)        fetch_pc <= fetch_pc + XLEN'(4);
        if (drop_discard) discard  <= discard - cnt_t'(1);
        if (accept) begin
          wr_ptr  <= wr_ptr + ptr_t'(1);
          resp_pc <= resp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
        case ({accept, pop})
          2'b10:   count <= count + cnt_t'(1);
          2'b01:   count <= count - cnt_t'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: queue storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge i_Clk) begin
    if (i_Rstn && accept) begin
      q_instr[wr_ptr] <= i_ReadData;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  assign o_ReadEn     = read_en;
  assign o_ReadAddr   = i_Rstn ? fetch_pc : RESET_PC;
  assign o_InstrValid = i_Rstn && !queue_empty;
  assign o_Instr      = o_InstrValid ? q_instr[rd_ptr] : 32'h0;
  assign o_PC         = o_InstrValid ? q_pc[rd_ptr] : '0;
  assign o_Event      = i_Rstn && event_q;

endmodule

// File: tb/tb_core_fetch_queue.sv
// Bench for core_fetch_queue: memory model with variable latency and a PC/instruction
// scoreboard fed from the architectural fetch stream (target, target+4, ...).
module tb_core_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h80;

  logic        clk;
  logic        rstn;
  logic        stall, flush, jump, branch;
  logic [31:0] jump_addr, branch_addr;
  logic        read_en;
  logic [31:0] read_addr;
  logic        read_gnt, read_valid;
  logic [31:0] read_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        evt;

  core_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_Clk(clk), .i_Rstn(rstn), .i_StallEn(stall), .i_FlushEn(flush),
    .i_JumpEn(jump), .i_JumpAddr(jump_addr), .i_BranchEn(branch), .i_BranchAddr(branch_addr),
    .o_ReadEn(read_en), .o_ReadAddr(read_addr), .i_ReadGnt(read_gnt),
    .i_ReadValid(read_valid), .i_ReadData(read_data),
    .o_InstrValid(instr_valid), .o_Instr(instr), .o_PC(pc), .o_Event(evt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory model: in-order responses, one per grant, latency lat_min..lat_max.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pending[$];
  int          cyc      = 0;
  int          last_due = 0;
  int          due_c;
  int          lat_min  = 1;
  int          lat_max  = 1;
  bit          gnt_rand = 0;
  int          n_grants = 0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (gnt_rand) read_gnt = ($urandom_range(0, 2) != 0);
    if (pending.size() != 0 && pending[0].due <= cyc) begin
      read_valid = 1'b1;
      read_data  = mem_word(pending[0].addr);
      pending.delete(0);
    end else begin
      read_valid = 1'b0;
      read_data  = $urandom;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      pending.delete();
      last_due  = 0;
      prev_wait = 0;
    end else begin
      if (prev_wait && read_en) check("addr_hold", read_addr, prev_addr);
      if (read_en && read_gnt) begin
        due_c = cyc + $urandom_range(lat_min, lat_max);
        if (due_c <= last_due) due_c = last_due + 1;
        pending.push_back('{read_addr, due_c});
        last_due = due_c;
        n_grants++;
      end
      prev_wait = read_en && !read_gnt;
      prev_addr = read_addr;
    end
  end

  // Scoreboard: expected decode stream for the current path, refilled after each drive.
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  bit          path_live  = 0;
  int          n_consumed = 0;

  task automatic start_path(input logic [31:0] t);
    exp_q.delete();
    exp_next  = t;
    path_live = 1;
  endtask

  always @(posedge clk) begin
    #3;
    if (path_live)
      while (exp_q.size() < 32) begin
        exp_q.push_back(exp_next);
        exp_next = exp_next + 32'd4;
      end
  end

  always @(negedge clk) begin
    if (rstn && instr_valid && !stall && !(flush || jump || branch)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual_pc=%0h required=none", pc);
      end else begin
        check("sb_pc", pc, exp_q[0]);
        check("sb_instr", instr, mem_word(exp_q[0]));
        exp_q.delete(0);
        n_consumed++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rstn      = 1'b0;
    path_live = 0;
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    n_grants = 0;
    @(negedge clk);
    check("rst_readen", read_en, 1'b0);
    check("rst_readaddr", read_addr, RESET_PC);
    check("rst_instrvalid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_event", evt, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    start_path(RESET_PC);
  endtask

  // Applies one redirect cycle; expected target and error pulse follow the priority rules.
  task automatic redirect(input bit f, input bit j, input bit b,
                          input logic [31:0] ja, input logic [31:0] ba, input int exp_en_n1);
    logic [31:0] raw;
    logic [31:0] tgt;
    bit          ev;
    raw = f ? RESET_PC : (j ? ja : ba);
    tgt = raw & ~32'h3;
    ev  = (!f && j && b) || (raw[1:0] != 2'b00);
    @(posedge clk); #1;
    flush = f; jump = j; branch = b; jump_addr = ja; branch_addr = ba;
    start_path(tgt);
    @(negedge clk);
    check("redir_readen_n", read_en, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; jump = 1'b0; branch = 1'b0;
    @(negedge clk);
    check("redir_event_n1", evt, ev);
    check("redir_addr_n1", read_addr, tgt);
    check("redir_empty_n1", instr_valid, 1'b0);
    if (exp_en_n1 >= 0) check("redir_readen_n1", read_en, exp_en_n1[0]);
    @(negedge clk);
    check("redir_event_n2", evt, 1'b0);
  endtask

  initial begin
    int          first;
    bit          f, j, b;
    logic [31:0] ja, ba;
    rstn = 1'b0; stall = 1'b0; flush = 1'b0; jump = 1'b0; branch = 1'b0;
    jump_addr = '0; branch_addr = '0; read_gnt = 1'b0; read_valid = 1'b0; read_data = '0;

    // Streaming from reset with a 1-cycle memory: first instruction after latency + 1.
    read_gnt = 1'b1;
    do_reset();
    @(negedge clk);
    check("release_readen", read_en, 1'b1);
    check("release_addr", read_addr, RESET_PC);
    first = -1;
    for (int k = 0; k < 10; k++) begin
      if (instr_valid && first < 0) first = k;
      @(negedge clk);
    end
    check("first_latency", first, 2);
    repeat (10) @(negedge clk);

    // Continuous stall fills the queue with exactly DEPTH requests.
    stall = 1'b1;
    do_reset();
    repeat (15) @(negedge clk);
    check("stall_grants", n_grants, DEPTH);
    check("stall_readen", read_en, 1'b0);
    check("stall_valid", instr_valid, 1'b1);
    check("stall_pc", pc, RESET_PC);
    @(posedge clk); #1;
    stall = 1'b0;
    repeat (12) @(negedge clk);
    check("stall_resume", n_grants > DEPTH, 1'b1);

    // Branch with three requests outstanding on a slow memory.
    lat_min = 5; lat_max = 5;
    do_reset();
    repeat (2) begin @(posedge clk); #1; end
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 1);
    repeat (20) @(negedge clk);

    // Random grants and latency, then the directed redirect corner cases.
    lat_min = 1; lat_max = 5;
    gnt_rand = 1;
    repeat (20) @(negedge clk);
    redirect(1'b0, 1'b1, 1'b1, 32'h200, 32'h300, -1);
    repeat (15) @(negedge clk);
    redirect(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, -1);
    repeat (15) @(negedge clk);
    redirect(1'b0, 1'b1, 1'b0, 32'h203, 32'h0, -1);
    repeat (15) @(negedge clk);
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF8, -1);
    repeat (25) @(negedge clk);

    // Randomised stall and redirect traffic.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) begin
        f  = ($urandom_range(0, 7) == 0);
        j  = $urandom_range(0, 1);
        b  = $urandom_range(0, 1);
        if (!f && !j) b = 1'b1;
        ja = $urandom;
        ba = $urandom;
        if ($urandom_range(0, 1) == 1) begin ja[1:0] = 2'b00; ba[1:0] = 2'b00; end
        redirect(f, j, b, ja, ba, -1);
      end
    end

    @(posedge clk); #1;
    stall = 1'b0;
    repeat (60) @(negedge clk);
    check("consumed_enough", n_consumed > 300, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
